// File: rtl/usb_bus_master.sv
// Strobe-bus master: turns read/write commands into RD_B/WR_B/address/data cycles
// with programmable setup, strobe and hold lengths. Define USB_BUS_MASTER_BURST_EN to honour CMD_LEN.
module usb_bus_master #(
  parameter int               ADD_W      = 16,
  parameter int               DATA_W     = 8,
  parameter int               LEN_W      = 8,
  parameter logic [ADD_W-1:0] ADD_OFFSET = ADD_W'('h4000),
  parameter int               SETUP_CYC  = 1,
  parameter int               STROBE_CYC = 2,
  parameter int               HOLD_CYC   = 1
) (
  input  logic              FCLK,
  input  logic              RST_B,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WR,
  input  logic [ADD_W-1:0]  CMD_ADD,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [LEN_W-1:0]  CMD_LEN,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_LAST,
  output logic [ADD_W-1:0]  BUS_ADD,
  output logic [DATA_W-1:0] BUS_DATA_OUT,
  output logic              BUS_DATA_OE,
  input  logic [DATA_W-1:0] BUS_DATA_IN,
  output logic              RD_B,
  output logic              WR_B
);

  localparam int CYC_MAX = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               wr_q, wr_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic [ADD_W-1:0]   bus_add_q, bus_add_d;
  logic [DATA_W-1:0]  bus_data_out_q, bus_data_out_d;
  logic               bus_data_oe_q, bus_data_oe_d;
  logic               rd_b_q, rd_b_d;
  logic               wr_b_q, wr_b_d;
  logic               last_word;

`ifdef USB_BUS_MASTER_BURST_EN
  logic [LEN_W-1:0]   words_q, words_d;
  logic [LEN_W-1:0]   cmd_words;

  // A zero length still moves one word.
  assign cmd_words = (CMD_LEN == '0) ? LEN_W'(1) : CMD_LEN;
  assign last_word = (words_q == LEN_W'(1));
`else
  logic               unused_len;

  assign unused_len = ^CMD_LEN;
  assign last_word  = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    cyc_d          = cyc_q;
    wr_d           = wr_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = 1'b0;
    rsp_data_d     = rsp_data_q;
    rsp_last_d     = 1'b0;
    bus_add_d      = bus_add_q;
    bus_data_out_d = bus_data_out_q;
    bus_data_oe_d  = bus_data_oe_q;
    rd_b_d         = rd_b_q;
    wr_b_d         = wr_b_q;
`ifdef USB_BUS_MASTER_BURST_EN
    words_d        = words_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // READY rises on the first edge out of reset and stays up while idle.
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && CMD_VALID) begin
          bus_add_d      = CMD_ADD + ADD_OFFSET;
          bus_data_out_d = CMD_DATA;
          bus_data_oe_d  = CMD_WR;
          wr_d           = CMD_WR;
          cmd_ready_d    = 1'b0;
          cyc_d          = CYC_W'(SETUP_CYC - 1);
          state_d        = S_SETUP;
`ifdef USB_BUS_MASTER_BURST_EN
          words_d        = cmd_words;
`endif
        end
      end

      S_SETUP: begin
        if (cyc_q == '0) begin
          cyc_d   = CYC_W'(STROBE_CYC - 1);
          state_d = S_STROBE;
          if (wr_q) wr_b_d = 1'b0;
          else      rd_b_d = 1'b0;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end

      S_STROBE: begin
        if (cyc_q == '0) begin
          rd_b_d  = 1'b1;
          wr_b_d  = 1'b1;
          cyc_d   = CYC_W'(HOLD_CYC - 1);
          state_d = S_HOLD;
          // Read data is sampled on the same edge the strobe rises.
          if (!wr_q) begin
            rsp_data_d  = BUS_DATA_IN;
            rsp_valid_d = 1'b1;
            rsp_last_d  = last_word;
          end
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end

      S_HOLD: begin
        if (cyc_q == '0) begin
`ifdef USB_BUS_MASTER_BURST_EN
          if (!last_word) begin
            words_d   = words_q - LEN_W'(1);
            bus_add_d = bus_add_q + ADD_W'(1);
            cyc_d     = CYC_W'(SETUP_CYC - 1);
            state_d   = S_SETUP;
          end else begin
            bus_data_oe_d = 1'b0;
            cmd_ready_d   = 1'b1;
            state_d       = S_IDLE;
          end
`else
          bus_data_oe_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = S_IDLE;
`endif
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge FCLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q        <= S_IDLE;
      cyc_q          <= '0;
      wr_q           <= 1'b0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_last_q     <= 1'b0;
      bus_add_q      <= '0;
      bus_data_out_q <= '0;
      bus_data_oe_q  <= 1'b0;
      rd_b_q         <= 1'b1;
      wr_b_q         <= 1'b1;
`ifdef USB_BUS_MASTER_BURST_EN
      words_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      wr_q           <= wr_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_last_q     <= rsp_last_d;
      bus_add_q      <= bus_add_d;
      bus_data_out_q <= bus_data_out_d;
      bus_data_oe_q  <= bus_data_oe_d;
      rd_b_q         <= rd_b_d;
      wr_b_q         <= wr_b_d;
`ifdef USB_BUS_MASTER_BURST_EN
      words_q        <= words_d;
`endif
    end
  end

  assign CMD_READY    = cmd_ready_q;
  assign RSP_VALID    = rsp_valid_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_LAST     = rsp_last_q;
  assign BUS_ADD      = bus_add_q;
  assign BUS_DATA_OUT = bus_data_out_q;
  assign BUS_DATA_OE  = bus_data_oe_q;
  assign RD_B         = rd_b_q;
  assign WR_B         = wr_b_q;

endmodule

// File: doc/usb_bus_master.md
# usb_bus_master

Synthesizable, parametrised master for the SiLibUSB-style external strobe bus. It turns single-word or burst read/write commands from on-chip logic into RD_B/WR_B/address/data sequences with programmable setup, strobe and hold lengths. Read data is returned on a response port. The block sits between a command source (sequencer, firmware bridge, test controller) and the FPGA pins of the external bus; tri-stating of the data pins is done at the top level from BUS_DATA_OUT/BUS_DATA_OE.

## Interface
Parameters:
- ADD_W, 16, bus address width
- DATA_W, 8, bus data width
- LEN_W, 8, burst length field width
- ADD_OFFSET, 16'h4000, added to CMD_ADD modulo 2^ADD_W before driving BUS_ADD
- SETUP_CYC, 1, cycles address/data are stable before strobe falls (>=1)
- STROBE_CYC, 2, cycles strobe is low (>=1)
- HOLD_CYC, 1, cycles address/data are held after strobe rises (>=1)

Ports:
- FCLK  in  1  single clock; everything is sampled on its rising edge
- RST_B  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted on edge where CMD_VALID & CMD_READY
- CMD_WR  in  1  1 = write, 0 = read
- CMD_ADD  in  ADD_W  start address before offset
- CMD_DATA  in  DATA_W  write data
- CMD_LEN  in  LEN_W  word count; 0 is treated as 1
- RSP_VALID  out  1  one-cycle pulse per read word; no backpressure
- RSP_DATA  out  DATA_W  read word
- RSP_LAST  out  1  high with RSP_VALID on the final word of a command
- BUS_ADD  out  ADD_W  external address
- BUS_DATA_OUT  out  DATA_W  external write data
- BUS_DATA_OE  out  1  data pin output enable
- BUS_DATA_IN  in  DATA_W  external read data
- RD_B  out  1  read strobe, active low
- WR_B  out  1  write strobe, active low

## Operation
- States: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- Reset values: CMD_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_LAST=0, BUS_ADD=0, BUS_DATA_OUT=0, BUS_DATA_OE=0, RD_B=1, WR_B=1. On the first edge after RST_B deasserts, CMD_READY rises and the state is IDLE.
- On accept (IDLE):
  - BUS_ADD <= CMD_ADD+ADD_OFFSET.
  - BUS_DATA_OUT <= CMD_DATA.
  - BUS_DATA_OE <= CMD_WR.
  - The word counter is loaded with max(CMD_LEN,1).
  - CMD_READY <= 0; go to SETUP.
- SETUP: count SETUP_CYC cycles, strobes high, then go to STROBE.
- STROBE: the strobe selected by CMD_WR is low for STROBE_CYC cycles; the other strobe stays high. RD_B and WR_B are never low together.
- Leaving STROBE: the strobe rises. For reads, BUS_DATA_IN is captured into RSP_DATA on this same edge, and RSP_VALID pulses during the following cycle. RSP_LAST is set when this is the final word.
- HOLD: address, data and OE are unchanged for HOLD_CYC cycles. Then:
  - If words remain: BUS_ADD <= BUS_ADD+1 (wraps modulo 2^ADD_W) and go to SETUP.
  - Otherwise: BUS_DATA_OE <= 0, CMD_READY <= 1, go to IDLE. BUS_ADD keeps its last value.
- Burst writes are fills: the same CMD_DATA goes to every address. Writes produce no response.
- CMD_VALID outside IDLE is ignored; command inputs are sampled only at accept.
- Reset asserted in any state forces reset values immediately. No RSP_VALID is produced for the interrupted word.

## Timing
- Accept edge = E0. Strobe falls at E0+SETUP_CYC and rises at E0+SETUP_CYC+STROBE_CYC (read sample edge).
- RSP_VALID is high from the sample edge to the next edge.
- Per-word period P = SETUP_CYC+STROBE_CYC+HOLD_CYC. Word k's address appears at E0+k·P.
- CMD_READY rises at E0+N·P. The earliest next accept is at E0+N·P+1 cycle.
- Defaults: P=4, matching the legacy bus model (address 1 cycle before strobe, 2-cycle strobe, 1-cycle hold).

## Configuration
- USB_BUS_MASTER_BURST_EN defined: CMD_LEN is honoured as described above.
- Not defined: CMD_LEN is ignored and every command transfers exactly one word. RSP_LAST is high on every RSP_VALID, and the address-increment logic is not built.

## Test plan
- Default read, CMD_ADD=0x0010, BUS_DATA_IN=0xA5 -> BUS_ADD=0x4010 at E0; RD_B low during E0+1..E0+3; RSP_VALID with RSP_DATA=0xA5, RSP_LAST=1 after E0+3; CMD_READY high at E0+4.
- Write 0x3C to 0x0002 -> BUS_ADD=0x4002; BUS_DATA_OUT=0x3C; OE high E0..E0+4; WR_B low 2 cycles; RD_B stays 1; no RSP_VALID.
- Burst read, macro on, CMD_LEN=4, CMD_ADD=0xBFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 at 4-cycle spacing; 4 RSP_VALID pulses, RSP_LAST only on the 4th; CMD_LEN=0 -> exactly 1 word.
- RST_B low while RD_B is low -> RD_B=1 and OE=0 immediately; no RSP_VALID; CMD_READY=1 one edge after release; a new read then completes normally.
- SETUP_CYC=3, STROBE_CYC=5, HOLD_CYC=2 -> strobe low exactly 5 cycles starting E0+3; word period 10; sample at E0+8.
- Macro off, CMD_LEN=4 write -> exactly one WR_B pulse; CMD_READY back at E0+4.
